alu_sequencer: RTL



---
 rtl/alu_ops_pkg.sv | 29 ++
 rtl/alu_sequencer_if.sv | 39 +++
 rtl/alu_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_ops_pkg.sv
// Shared definitions for the ALU sequencer: opcode values, FSM state type and
// the helper that tells which operations return a two-word result.
package alu_ops_pkg;

    localparam int OP_W   = 5;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_NOP = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD = 5'd2;
    localparam logic [OP_W-1:0] OP_SUB = 5'd3;
    localparam logic [OP_W-1:0] OP_AND = 5'd4;
    localparam logic [OP_W-1:0] OP_OR  = 5'd5;
    localparam logic [OP_W-1:0] OP_XOR = 5'd6;
    localparam logic [OP_W-1:0] OP_MUL = 5'd15;
    localparam logic [OP_W-1:0] OP_DIV = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_RESP_LO = 2'd2,
        ST_RESP_HI = 2'd3
    } seq_state_e;

    // MUL returns a 64-bit product, DIV returns quotient then remainder.
    function automatic logic is_two_beat(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU datapath and response signals between the sequencer (slave)
// and its surroundings (master: requester, external ALU and response consumer).
interface alu_sequencer_if;
    import alu_ops_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result_low;
    logic [DATA_W-1:0] alu_result_high;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_high;
    logic              rsp_last;
    logic              busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result_low, alu_result_high, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_data, rsp_high, rsp_last, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result_low, alu_result_high, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_data, rsp_high, rsp_last, busy
    );

endinterface

// File: rtl/alu_sequencer.sv
// Sequences one request through an external fixed-latency ALU and returns the
// result as one beat, or two beats (low then high word) for MUL/DIV.
module alu_sequencer
    import alu_ops_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic     clock,
    input  logic     clear,
    alu_sequencer_if.slave bus
);

    localparam logic [1:0] LAST_CNT = 2'(ALU_LATENCY - 1);

    seq_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] z_low_q, z_low_d;
    logic [DATA_W-1:0] z_high_q, z_high_d;
    logic [1:0]        cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            z_low_q  <= '0;
            z_high_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_low_q  <= z_low_d;
            z_high_q <= z_high_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        z_low_d  = z_low_q;
        z_high_d = z_high_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Operands have been stable for ALU_LATENCY cycles on the last edge.
                if (cnt_q == LAST_CNT) begin
                    z_low_d  = bus.alu_result_low;
                    z_high_d = bus.alu_result_high;
                    state_d  = ST_RESP_LO;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RESP_LO: begin
                if (bus.rsp_ready) begin
                    state_d = is_two_beat(op_q) ? ST_RESP_HI : ST_IDLE;
                end
            end
            ST_RESP_HI: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;

    // Response fields read as zero whenever no beat is being offered.
    always_comb begin
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_high  = 1'b0;
        bus.rsp_last  = 1'b0;
        case (state_q)
            ST_RESP_LO: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = z_low_q;
                bus.rsp_last  = !is_two_beat(op_q);
            end
            ST_RESP_HI: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = z_high_q;
                bus.rsp_high  = 1'b1;
                bus.rsp_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
